usb_desc_streamer: RTL and testbench

Control-endpoint descriptor fetch unit between the standard-request decoder and the EP0 transmit path. It takes a decoded GET_DESCRIPTOR request (type, index, wLength) and resolves the descriptor's ROM start address through the descriptor start LUT. It then determines the descriptor length from the ROM and streams min(wLength, length) bytes, split into packets of the EP0 max packet size. Retransmission of a packet is owned by the EP0 TX buffer; this block only produces each packet once.

---
 rtl/usb_desc_streamer_if.sv | 38 +++
 rtl/usb_desc_streamer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_usb_desc_streamer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_desc_streamer_if.sv
// usb_desc_streamer_if
//   Groups the request, byte-stream and transfer-control signals shared between
//   the standard-request decoder / EP0 TX buffer (master) and the descriptor
//   streamer (slave).
//   Request   : reqValid/reqReady, reqDescType, reqDescIndex, reqLength, maxPacketSize
//   Stream    : dataValid/dataReady, data, dataLast
//   Control   : nextPacket, abort (to streamer); xferDone, zlpNeeded, stall (from streamer)
interface usb_desc_streamer_if;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqDescType;
  logic [7:0]  reqDescIndex;
  logic [15:0] reqLength;
  logic [1:0]  maxPacketSize;

  logic        dataValid;
  logic        dataReady;
  logic [7:0]  data;
  logic        dataLast;

  logic        nextPacket;
  logic        zlpNeeded;
  logic        xferDone;
  logic        stall;
  logic        abort;

  modport master (
    output reqValid, reqDescType, reqDescIndex, reqLength, maxPacketSize,
    output dataReady, nextPacket, abort,
    input  reqReady, dataValid, data, dataLast, zlpNeeded, xferDone, stall
  );

  modport slave (
    input  reqValid, reqDescType, reqDescIndex, reqLength, maxPacketSize,
    input  dataReady, nextPacket, abort,
    output reqReady, dataValid, data, dataLast, zlpNeeded, xferDone, stall
  );
endinterface

// File: rtl/usb_desc_streamer.sv
// usb_desc_streamer
//   GET_DESCRIPTOR fetch unit for the control endpoint. Resolves the descriptor
//   start address (fixed 0 for DEVICE, start LUT otherwise), reads the
//   descriptor length from ROM, then streams min(wLength, length) bytes in
//   packets of the EP0 max packet size, waiting for nextPacket between packets.
// Ports
//   clk48, rst      : single clock, synchronous active-high reset
//   bus (slave)     : request, byte stream and transfer-control handshakes
//   lutIdx          : start LUT index (registered at request accept)
//   lutStartAddr    : combinational LUT result for lutIdx
//   romAddr         : descriptor ROM address
//   romData         : ROM data, valid one cycle after romAddr
module usb_desc_streamer #(
  parameter int ROM_ADDR_W  = 10,
  parameter int LUT_IDX_W   = 4,
  parameter int NUM_CONFIGS = 1,
  parameter int NUM_STRINGS = 0
) (
  input  logic                  clk48,
  input  logic                  rst,
  usb_desc_streamer_if.slave    bus,
  output logic [LUT_IDX_W-1:0]  lutIdx,
  input  logic [ROM_ADDR_W-1:0] lutStartAddr,
  output logic [ROM_ADDR_W-1:0] romAddr,
  input  logic [7:0]            romData
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, HDR, STREAM, PKT_WAIT, DONE, ERROR
  } stateT;

  stateT state, stateNext;

  // Request context captured at accept
  logic                  isDevice, isConfig;
  logic [15:0]           reqLen;
  logic [1:0]            mpsCode;
  logic [ROM_ADDR_W-1:0] startAddr;
  logic [7:0]            lenLo;
  logic                  hdrStep;
  logic [15:0]           sendLen;

  // Read issue side
  logic [ROM_ADDR_W-1:0] readPtr;
  logic [6:0]            pktIssued;
  logic [15:0]           totalIssued;
  logic                  pktIssueDone;
  logic                  finalPkt;
  logic                  inFlight, inFlightLast;

  // Prefetch entry plus registered output stage
  logic                  skidValid, skidLast;
  logic [7:0]            skidData;
  logic                  dataValidQ, dataLastQ;
  logic [7:0]            dataQ;

  // Combinational helpers
  logic                  accept, reqOk;
  logic [LUT_IDX_W-1:0]  reqLutIdx;
  logic [ROM_ADDR_W-1:0] lookupStart, hdrAddr;
  logic                  hdrFinal;
  logic [15:0]           descLenNow, sendLenNow;
  logic [6:0]            mpsBytes;
  logic [15:0]           mpsMask;
  logic                  zlpCond;
  logic                  pop, issue, issueLast, issueFinal;
  logic [1:0]            occNext;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign accept = (state == IDLE) && bus.reqValid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    reqOk     = 1'b0;
    reqLutIdx = '0;
    case (bus.reqDescType)
      8'd1: reqOk = 1'b1;
      8'd2: begin
        reqOk     = int'(bus.reqDescIndex) < NUM_CONFIGS;
        reqLutIdx = LUT_IDX_W'(int'(bus.reqDescIndex));
      end
      8'd3: begin
        // String zero sits right after the configurations in the LUT.
        reqOk     = (NUM_STRINGS > 0) && (int'(bus.reqDescIndex) <= NUM_STRINGS);
        reqLutIdx = LUT_IDX_W'(NUM_CONFIGS + int'(bus.reqDescIndex));
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address / length helpers
  // ---------------------------------------------------------------------------
  assign lookupStart = isDevice ? '0 : lutStartAddr;
  // wTotalLength lives at bytes 2..3 of a configuration descriptor.
  assign hdrAddr     = isConfig ? lookupStart + ROM_ADDR_W'(2) : lookupStart;
  // The LUT answer is only valid during LOOKUP, so the first header read is
  // presented straight from it to save a cycle; afterwards readPtr drives ROM.
  assign romAddr     = (state == LOOKUP) ? hdrAddr : readPtr;

  assign hdrFinal    = !isConfig || hdrStep;
  assign descLenNow  = isConfig ? {romData, lenLo} : {8'h00, romData};
  assign sendLenNow  = (reqLen < descLenNow) ? reqLen : descLenNow;

  assign mpsBytes    = 7'd8 << mpsCode;
  assign mpsMask     = {9'd0, mpsBytes - 7'd1};
  assign zlpCond     = (sendLen < reqLen) && ((sendLen & mpsMask) == 16'd0) &&
                       (sendLen != 16'd0);

  // A read may be issued only if, whatever the consumer does next cycle, the
  // returning byte still finds room in output stage + prefetch entry.
  assign pop        = dataValidQ && bus.dataReady;
  assign occNext    = 2'(dataValidQ) + 2'(skidValid) + 2'(inFlight) - 2'(pop);
  assign issue      = (state == STREAM) && !pktIssueDone && (occNext <= 2'd1);
  assign issueFinal = (totalIssued + 16'd1) == sendLen;
  assign issueLast  = ((pktIssued + 7'd1) == mpsBytes) || issueFinal;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk48) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || bus.abort) state <= IDLE;
    else                  state <= stateNext;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (bus.reqValid) stateNext = reqOk ? LOOKUP : ERROR;
      LOOKUP:   stateNext = HDR;
      HDR:      if (hdrFinal) stateNext = (sendLenNow == 16'd0) ? DONE : STREAM;
      STREAM:   if (pop && dataLastQ) stateNext = PKT_WAIT;
      PKT_WAIT: if (bus.nextPacket) stateNext = finalPkt ? DONE : STREAM;
      DONE:     stateNext = IDLE;
      ERROR:    stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.reqReady  = 1'b0;
    bus.xferDone  = 1'b0;
    bus.zlpNeeded = 1'b0;
    bus.stall     = 1'b0;
    case (state)
      IDLE:  bus.reqReady = 1'b1;
      DONE: begin
        bus.xferDone  = 1'b1;
        bus.zlpNeeded = zlpCond;
      end
      ERROR: bus.stall = 1'b1;
      default: ;
    endcase
  end

  assign bus.dataValid = dataValidQ;
  assign bus.data      = dataQ;
  assign bus.dataLast  = dataLastQ;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk48) begin
    if (rst || bus.abort) begin
      // NOTE: the byte-holding registers are cleared too, so data reads 0
      // after reset/abort instead of a stale descriptor byte.
      lutIdx       <= '0;
      isDevice     <= 1'b0;
      isConfig     <= 1'b0;
      reqLen       <= '0;
      mpsCode      <= '0;
      startAddr    <= '0;
      lenLo        <= '0;
      hdrStep      <= 1'b0;
      sendLen      <= '0;
      readPtr      <= '0;
      pktIssued    <= '0;
      totalIssued  <= '0;
      pktIssueDone <= 1'b0;
      finalPkt     <= 1'b0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      skidValid    <= 1'b0;
      skidLast     <= 1'b0;
      skidData     <= '0;
      dataValidQ   <= 1'b0;
      dataLastQ    <= 1'b0;
      dataQ        <= '0;
    end else begin
      if (accept) begin
        lutIdx       <= reqLutIdx;
        isDevice     <= bus.reqDescType == 8'd1;
        isConfig     <= bus.reqDescType == 8'd2;
        reqLen       <= bus.reqLength;
        mpsCode      <= bus.maxPacketSize;
        pktIssued    <= '0;
        totalIssued  <= '0;
        pktIssueDone <= 1'b0;
        finalPkt     <= 1'b0;
      end

      if (state == LOOKUP) begin
        startAddr <= lookupStart;
        // Config needs byte 3 next; otherwise the header byte is also byte 0
        // of the stream, so the pointer parks on the start address.
        readPtr   <= isConfig ? hdrAddr + ROM_ADDR_W'(1) : lookupStart;
        hdrStep   <= 1'b0;
      end

      if (state == HDR) begin
        if (!hdrFinal) begin
          lenLo   <= romData;
          readPtr <= startAddr;
          hdrStep <= 1'b1;
        end else begin
          sendLen <= sendLenNow;
        end
      end

      if ((state == PKT_WAIT) && bus.nextPacket) begin
        pktIssued    <= '0;
        pktIssueDone <= 1'b0;
      end

      inFlight <= issue;
      if (issue) begin
        readPtr      <= readPtr + ROM_ADDR_W'(1);
        pktIssued    <= pktIssued + 7'd1;
        totalIssued  <= totalIssued + 16'd1;
        inFlightLast <= issueLast;
        if (issueLast) begin
          pktIssueDone <= 1'b1;
          finalPkt     <= issueFinal;
        end
      end

      // Output stage refills from the prefetch entry first to keep byte order.
      if (!dataValidQ || pop) begin
        if (skidValid) begin
          dataQ      <= skidData;
          dataLastQ  <= skidLast;
          dataValidQ <= 1'b1;
          skidValid  <= inFlight;
          skidData   <= romData;
          skidLast   <= inFlightLast;
        end else if (inFlight) begin
          dataQ      <= romData;
          dataLastQ  <= inFlightLast;
          dataValidQ <= 1'b1;
        end else begin
          dataValidQ <= 1'b0;
          dataLastQ  <= 1'b0;
        end
      end else if (inFlight) begin
        skidValid <= 1'b1;
        skidData  <= romData;
        skidLast  <= inFlightLast;
      end
    end
  end

endmodule

// File: tb/tb_usb_desc_streamer.sv
// tb_usb_desc_streamer
//   Directed bench for usb_desc_streamer with a behavioural registered ROM and
//   start LUT. Descriptors: DEVICE @0 (18 B), CONFIG0 @64 (wTotalLength 32),
//   STRING0 @128 (4 B), STRING1 @160 (10 B), STRING2 @192 (6 B).
module tb_usb_desc_streamer;
  localparam int ROM_ADDR_W  = 10;
  localparam int LUT_IDX_W   = 4;
  localparam int NUM_CONFIGS = 1;
  localparam int NUM_STRINGS = 2;

  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk48 = ~clk48;

  usb_desc_streamer_if bus ();

  logic [LUT_IDX_W-1:0]  lutIdx;
  logic [ROM_ADDR_W-1:0] lutStartAddr;
  logic [ROM_ADDR_W-1:0] romAddr;
  logic [7:0]            romData;

  logic [7:0]            rom [1024];
  logic [ROM_ADDR_W-1:0] lut [16];

  assign lutStartAddr = lut[lutIdx];
  always @(posedge clk48) romData <= rom[romAddr];

  usb_desc_streamer #(
    .ROM_ADDR_W  (ROM_ADDR_W),
    .LUT_IDX_W   (LUT_IDX_W),
    .NUM_CONFIGS (NUM_CONFIGS),
    .NUM_STRINGS (NUM_STRINGS)
  ) dut (
    .clk48        (clk48),
    .rst          (rst),
    .bus          (bus),
    .lutIdx       (lutIdx),
    .lutStartAddr (lutStartAddr),
    .romAddr      (romAddr),
    .romData      (romData)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " reqReady"},  bus.reqReady, 1);
    check({tag, " dataValid"}, bus.dataValid, 0);
    check({tag, " dataLast"},  bus.dataLast, 0);
    check({tag, " xferDone"},  bus.xferDone, 0);
    check({tag, " zlpNeeded"}, bus.zlpNeeded, 0);
    check({tag, " stall"},     bus.stall, 0);
    check({tag, " romAddr"},   romAddr, 0);
    check({tag, " lutIdx"},    lutIdx, 0);
    check({tag, " data"},      bus.data, 0);
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic sendReq(input logic [7:0] t, input logic [7:0] idx,
                         input logic [15:0] len, input logic [1:0] mps);
    check("reqReady before request", bus.reqReady, 1);
    bus.reqValid      = 1'b1;
    bus.reqDescType   = t;
    bus.reqDescIndex  = idx;
    bus.reqLength     = len;
    bus.maxPacketSize = mps;
    @(negedge clk48);
    bus.reqValid = 1'b0;
  endtask

  // Consumes the stream, checking every byte and dataLast against the ROM
  // model. abortAt >= 0 cancels (abort or rst) once that many bytes were taken.
  task automatic runXfer(input string tag, input int start, input int sendLen,
                         input int mpsBytes, input logic expZlp, input bit randReady,
                         input int abortAt, input bit useRst, input int maxFirst);
    int   got = 0;
    int   inPkt = 0;
    int   nextDelay = 0;
    int   firstCyc = -1;
    bit   done = 0;
    bit   held = 0;
    bit   ready;
    bit   expLast;
    logic [7:0] heldData = '0;
    logic       heldLast = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (got == abortAt) begin
        if (useRst) rst = 1'b1;
        else        bus.abort = 1'b1;
        bus.dataReady  = 1'b0;
        bus.nextPacket = 1'b0;
        break;
      end
      if (held) begin
        check({tag, " hold valid"}, bus.dataValid, 1);
        check({tag, " hold data"},  bus.data, heldData);
        check({tag, " hold last"},  bus.dataLast, heldLast);
      end
      if (bus.xferDone) begin
        check({tag, " byte count"}, got, sendLen);
        check({tag, " zlpNeeded"},  bus.zlpNeeded, expZlp);
        done = 1;
        break;
      end
      if (bus.dataValid && firstCyc < 0) firstCyc = cyc;
      ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.dataReady  = ready;
      bus.nextPacket = 1'b0;
      if (nextDelay > 0) begin
        nextDelay--;
        if (nextDelay == 0) bus.nextPacket = 1'b1;
      end
      held     = bus.dataValid && !ready;
      heldData = bus.data;
      heldLast = bus.dataLast;
      if (bus.dataValid && ready) begin
        check({tag, " data"}, bus.data, rom[start + got]);
        expLast = (inPkt + 1 == mpsBytes) || (got + 1 == sendLen);
        check({tag, " dataLast"}, bus.dataLast, expLast);
        got++;
        inPkt++;
        if (expLast) begin
          inPkt     = 0;
          nextDelay = 2;
        end
      end
      @(negedge clk48);
    end
    bus.nextPacket = 1'b0;
    if (abortAt < 0) begin
      check({tag, " completed in budget"}, done, 1);
      if (maxFirst >= 0) check({tag, " first byte latency ok"}, firstCyc <= maxFirst, 1);
      if (sendLen == 0) check({tag, " no data"}, firstCyc, -1);
      @(negedge clk48);
    end
  endtask

  typedef struct { logic [7:0] t; logic [7:0] idx; } badReqT;
  badReqT badReqs [3] = '{'{8'd3, 8'd3}, '{8'd7, 8'd0}, '{8'd2, 8'd1}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'd18;  rom[1] = 8'd1;
    rom[64] = 8'd9;  rom[65] = 8'd2; rom[66] = 8'd32; rom[67] = 8'd0;
    rom[128] = 8'd4; rom[129] = 8'd3;
    rom[160] = 8'd10;
    rom[192] = 8'd6;
    for (int i = 0; i < 16; i++) lut[i] = '0;
    lut[0] = 10'd64; lut[1] = 10'd128; lut[2] = 10'd160; lut[3] = 10'd192;

    bus.reqValid = 0; bus.reqDescType = 0; bus.reqDescIndex = 0; bus.reqLength = 0;
    bus.maxPacketSize = 0; bus.dataReady = 0; bus.nextPacket = 0; bus.abort = 0;

    repeat (2) @(negedge clk48);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk48);

    // DEVICE, 18 bytes in 8-byte packets: 8, 8, 2, no ZLP
    sendReq(8'd1, 8'd0, 16'd64, 2'd0);
    runXfer("dev mps8", 0, 18, 8, 1'b0, 1'b0, -1, 1'b0, 5);

    // CONFIG0, 32 bytes < wLength 255 and multiple of 8: ZLP
    sendReq(8'd2, 8'd0, 16'd255, 2'd0);
    runXfer("cfg mps8", 64, 32, 8, 1'b1, 1'b0, -1, 1'b0, 5);

    // CONFIG0 truncated to wLength 9
    sendReq(8'd2, 8'd0, 16'd9, 2'd1);
    runXfer("cfg len9", 64, 9, 16, 1'b0, 1'b0, -1, 1'b0, 5);

    // CONFIG0, wLength equals descriptor length: no ZLP
    sendReq(8'd2, 8'd0, 16'd32, 2'd2);
    runXfer("cfg len32", 64, 32, 32, 1'b0, 1'b0, -1, 1'b0, 5);

    // STRING0 and STRING2 (truncated)
    sendReq(8'd3, 8'd0, 16'd255, 2'd3);
    runXfer("str0", 128, 4, 64, 1'b0, 1'b0, -1, 1'b0, 5);
    sendReq(8'd3, 8'd2, 16'd3, 2'd0);
    runXfer("str2", 192, 3, 8, 1'b0, 1'b0, -1, 1'b0, 5);

    // Invalid requests: stall exactly at T+1, nothing streamed
    foreach (badReqs[i]) begin
      sendReq(badReqs[i].t, badReqs[i].idx, 16'd64, 2'd0);
      check("bad req stall at T+1", bus.stall, 1);
      check("bad req no data", bus.dataValid, 0);
      @(negedge clk48);
      check("bad req stall pulse width", bus.stall, 0);
      check("bad req back to idle", bus.reqReady, 1);
      check("bad req no data after", bus.dataValid, 0);
    end

    // Abort mid-transfer with random backpressure, then a fresh request
    sendReq(8'd2, 8'd0, 16'd255, 2'd0);
    runXfer("abort", 64, 32, 8, 1'b0, 1'b1, 5, 1'b0, -1);
    @(negedge clk48);
    bus.abort = 1'b0;
    check("abort dataValid", bus.dataValid, 0);
    check("abort reqReady", bus.reqReady, 1);
    check("abort no xferDone", bus.xferDone, 0);
    check("abort no stall", bus.stall, 0);
    sendReq(8'd1, 8'd0, 16'd64, 2'd1);
    runXfer("after abort", 0, 18, 16, 1'b0, 1'b1, -1, 1'b0, -1);

    // Zero wLength: completion with no data and no ZLP
    sendReq(8'd1, 8'd0, 16'd0, 2'd0);
    runXfer("len0", 0, 0, 8, 1'b0, 1'b0, -1, 1'b0, -1);

    // Reset while streaming
    sendReq(8'd1, 8'd0, 16'd64, 2'd0);
    runXfer("rst", 0, 18, 8, 1'b0, 1'b0, 3, 1'b1, -1);
    @(negedge clk48);
    checkResetOutputs("rst in stream");
    rst = 1'b0;
    @(negedge clk48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
